led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
Parametrised successor to the single free-running LED blinker. It drives N_LEDS outputs, each with its own run-time mode: off, steady (PWM-dimmed), blink, or breathe. All timing derives from one shared prescaler tick. Sits beside the board I/O in the sys domain; a CSR/bridge master programs channels through a valid/ready config port.

Parameters:
N_LEDS, 4, number of LED channels (1..16)
CLK_FREQ, 50000000, sys_clk frequency in Hz
TICK_HZ, 1000, prescaler tick rate in Hz; tick period = CLK_FREQ/TICK_HZ cycles (integer, >=2)
PWM_BITS, 8, brightness resolution; MAX = 2^PWM_BITS-1
BOOT_BLINK, 1, if 1 channel 0 resets to BLINK, period 500, duty MAX (power-on heartbeat)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous active-high reset
cfg_valid  in  1  config request
cfg_ready  out  1  config accept
cfg_chan  in  max(1,clog2(N_LEDS))  target channel
cfg_mode  in  2  0=OFF 1=ON 2=BLINK 3=BREATHE
cfg_period  in  16  ticks per phase event (0 treated as 1)
cfg_duty  in  PWM_BITS  brightness (ON/BLINK) or peak (BREATHE)
user_led  out  N_LEDS  LED drive, registered
tick  out  1  one-cycle prescaler strobe

Behaviour:
- Reset (async assert, sync release): user_led=0, tick=0, cfg_ready=0, prescaler=0, pwm_cnt=0. All channels mode=OFF, period=1, duty=0, phase_cnt=0, blink_on=1, level=0, dir=up. If BOOT_BLINK=1, ch0 is instead mode=BLINK, period=500, duty=MAX.
- cfg_ready=1 in every cycle after reset release; it drops only while sys_rst is high.
- A config is accepted on cfg_valid & cfg_ready. Starting the next cycle, the channel uses the new mode/period/duty, with phase_cnt=0, blink_on=1, level=0, dir=up.
- cfg_chan >= N_LEDS: the request is accepted and discarded with no state change.
- Prescaler: counts 0..CLK_FREQ/TICK_HZ-1 and wraps. tick=1 for the cycle in which the count equals the terminal value (registered), so the first tick occurs CLK_FREQ/TICK_HZ cycles after reset release.
- Phase event, per channel: on each cycle with tick=1, phase_cnt increments. When phase_cnt = eff_period-1 (eff_period = max(period,1)), phase_cnt instead clears and an event fires.
- BLINK event: toggle blink_on.
- BREATHE event:
  - dir=up: level+1. On reaching duty, set dir=down.
  - dir=down: level-1. On reaching 0, set dir=up.
  - duty=0: level stays 0.
- OFF and ON: events have no effect.
- PWM: pwm_cnt is a PWM_BITS-bit free-running counter that increments every cycle and wraps MAX->0.
- Compare level L: OFF uses L=0; ON uses duty; BLINK uses duty when blink_on=1, else 0; BREATHE uses level.
- lit = (L==MAX) | (pwm_cnt < L). user_led[i] <= lit, one register stage. L=0 gives never lit; L=MAX gives always lit.
- Simultaneous config accept and phase event on the same channel: config wins and the event is dropped. Events on other channels proceed normally.
- Reset mid-operation: all state returns to reset values immediately; there is no partial pattern state.
- No combinational path from cfg_* to user_led.

Test Plan:
- Bench params: CLK_FREQ=100, TICK_HZ=10, PWM_BITS=4, N_LEDS=4.
- Reset/boot: BOOT_BLINK=1, release reset -> user_led=4'b0001 from cycle 1. tick first high at cycle 10, then every 10 cycles. ch0 first goes low after 500 ticks (5000 cycles) and toggles every 5000 cycles thereafter.
- ON dimming: ch1 ON with duty=4 -> user_led[1] high exactly 4 of every 16 cycles. duty=15 -> constant 1. duty=0 -> constant 0.
- BLINK: ch2 with period=3, duty=15 -> high for 30 cycles, then low for 30, repeating. The first high phase begins the cycle after accept. period=0 behaves as period=1 (10-cycle toggle).
- BREATHE: ch3 with period=1, duty=3 -> level sequence per tick is 0,1,2,3,2,1,0,1... Duty-cycle count per 16-cycle window matches the level each time.
- Collision: write ch2 in the same cycle as its phase event -> blink_on=1 and phase_cnt=0 afterwards. cfg_chan=5 -> accepted (cfg_ready=1) and all channels unchanged.
- Async reset: assert sys_rst mid-BREATHE, between clock edges -> user_led=0 and cfg_ready=0 without waiting for a clock edge. After release, all state equals the post-reset values.

Source files
------------

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel OFF / ON / BLINK / BREATHE
// modes, all paced by one shared prescaler tick and dimmed by a common PWM counter.
module led_pattern_gen #(
  parameter int N_LEDS     = 4,
  parameter int CLK_FREQ   = 50000000,
  parameter int TICK_HZ    = 1000,
  parameter int PWM_BITS   = 8,
  parameter int BOOT_BLINK = 1
) (
  input  logic                                          sys_clk,
  input  logic                                          sys_rst,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  input  logic [((N_LEDS > 1) ? $clog2(N_LEDS) : 1)-1:0] cfg_chan,
  input  logic [1:0]                                    cfg_mode,
  input  logic [15:0]                                   cfg_period,
  input  logic [PWM_BITS-1:0]                           cfg_duty,
  output logic [N_LEDS-1:0]                             user_led,
  output logic                                          tick
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]       PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]       PRESC_ONE  = PW'(1);
  localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
  localparam logic [PWM_BITS-1:0] PWM_ONE    = PWM_BITS'(1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  // Config handshake: a request transfers on any cycle where cfg_valid and
  // cfg_ready are both high; the master holds its fields stable until then.
  logic                cfg_fire;
  logic [31:0]         chan_ext;
  logic                ready_q, ready_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                tick_q, tick_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [N_LEDS-1:0]   led_q, led_d;

  mode_e               mode_q     [N_LEDS];
  mode_e               mode_d     [N_LEDS];
  logic [15:0]         period_q   [N_LEDS];
  logic [15:0]         period_d   [N_LEDS];
  logic [PWM_BITS-1:0] duty_q     [N_LEDS];
  logic [PWM_BITS-1:0] duty_d     [N_LEDS];
  logic [15:0]         phase_q    [N_LEDS];
  logic [15:0]         phase_d    [N_LEDS];
  logic                blink_on_q [N_LEDS];
  logic                blink_on_d [N_LEDS];
  logic [PWM_BITS-1:0] level_q    [N_LEDS];
  logic [PWM_BITS-1:0] level_d    [N_LEDS];
  logic                down_q     [N_LEDS];
  logic                down_d     [N_LEDS];

  assign cfg_fire  = cfg_valid & ready_q;
  assign chan_ext  = 32'(cfg_chan);
  assign cfg_ready = ready_q;
  assign user_led  = led_q;
  assign tick      = tick_q;

  always_comb begin
    logic [15:0]         term;
    logic                ev;
    logic [PWM_BITS-1:0] lvl;
    term    = '0;
    ev      = 1'b0;
    lvl     = '0;
    ready_d = 1'b1;
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_ONE;
    tick_d  = (presc_q == PRESC_LAST);
    pwm_d   = pwm_q + PWM_ONE;
    led_d   = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      mode_d[i]     = mode_q[i];
      period_d[i]   = period_q[i];
      duty_d[i]     = duty_q[i];
      phase_d[i]    = phase_q[i];
      blink_on_d[i] = blink_on_q[i];
      level_d[i]    = level_q[i];
      down_d[i]     = down_q[i];

      // A zero period behaves as one tick per event.
      term = (period_q[i] == 16'd0) ? 16'd0 : period_q[i] - 16'd1;
      ev   = tick_q && (phase_q[i] == term);
      if (tick_q) phase_d[i] = ev ? 16'd0 : phase_q[i] + 16'd1;

      if (ev) begin
        case (mode_q[i])
          MODE_BLINK: blink_on_d[i] = ~blink_on_q[i];
          MODE_BREATHE: begin
            if (duty_q[i] != '0) begin
              if (!down_q[i]) begin
                level_d[i] = level_q[i] + PWM_ONE;
                if (level_q[i] + PWM_ONE == duty_q[i]) down_d[i] = 1'b1;
              end else begin
                level_d[i] = level_q[i] - PWM_ONE;
                if (level_q[i] == PWM_ONE) down_d[i] = 1'b0;
              end
            end
          end
          default: ;
        endcase
      end

      // An accepted write overrides any event landing on the same edge.
      if (cfg_fire && (chan_ext == 32'(i))) begin
        mode_d[i]     = mode_e'(cfg_mode);
        period_d[i]   = cfg_period;
        duty_d[i]     = cfg_duty;
        phase_d[i]    = 16'd0;
        blink_on_d[i] = 1'b1;
        level_d[i]    = '0;
        down_d[i]     = 1'b0;
      end

      case (mode_q[i])
        MODE_ON:      lvl = duty_q[i];
        MODE_BLINK:   lvl = blink_on_q[i] ? duty_q[i] : '0;
        MODE_BREATHE: lvl = level_q[i];
        default:      lvl = '0;
      endcase
      led_d[i] = (lvl == PWM_MAX) || (pwm_q < lvl);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ready_q <= 1'b0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      pwm_q   <= '0;
      led_q   <= '0;
      for (int i = 0; i < N_LEDS; i++) begin
        if ((i == 0) && (BOOT_BLINK == 1)) begin
          mode_q[i]   <= MODE_BLINK;
          period_q[i] <= 16'd500;
          duty_q[i]   <= PWM_MAX;
        end else begin
          mode_q[i]   <= MODE_OFF;
          period_q[i] <= 16'd1;
          duty_q[i]   <= '0;
        end
        phase_q[i]    <= 16'd0;
        blink_on_q[i] <= 1'b1;
        level_q[i]    <= '0;
        down_q[i]     <= 1'b0;
      end
    end else begin
      ready_q <= ready_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
      for (int i = 0; i < N_LEDS; i++) begin
        mode_q[i]     <= mode_d[i];
        period_q[i]   <= period_d[i];
        duty_q[i]     <= duty_d[i];
        phase_q[i]    <= phase_d[i];
        blink_on_q[i] <= blink_on_d[i];
        level_q[i]    <= level_d[i];
        down_q[i]     <= down_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: boot heartbeat, dimming table, blink and
// breathe timing, config/event collision, out-of-range channel and async reset.
module tb_led_pattern_gen;

  localparam int CLK_FREQ = 100;
  localparam int TICK_HZ  = 10;
  localparam int PWM_BITS = 4;
  localparam int N_LEDS   = 4;

  localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_BREATHE = 2'd3;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          cfg_valid = 1'b0, cfg_valid_b = 1'b0;
  logic [1:0]    cfg_chan = '0;
  logic [2:0]    cfg_chan_b = '0;
  logic [1:0]    cfg_mode = '0;
  logic [15:0]   cfg_period = '0;
  logic [3:0]    cfg_duty = '0;
  logic          cfg_ready, cfg_ready_b, tick, tick_b;
  logic [3:0]    user_led;
  logic [4:0]    user_led_b;

  int cyc;
  int n_cmp = 0;
  int n_err = 0;

  led_pattern_gen #(.N_LEDS(N_LEDS), .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ),
                    .PWM_BITS(PWM_BITS), .BOOT_BLINK(1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_duty(cfg_duty), .user_led(user_led), .tick(tick)
  );

  // Five-channel instance so that channel numbers 5..7 are representable.
  led_pattern_gen #(.N_LEDS(5), .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ),
                    .PWM_BITS(PWM_BITS), .BOOT_BLINK(0)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
    .cfg_chan(cfg_chan_b), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_duty(cfg_duty), .user_led(user_led_b), .tick(tick_b)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d expected the test to have ended", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    int         chan;
    logic [1:0] mode;
    int         period;
    int         duty;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // driver tasks: all called and returning at a falling edge
  task automatic cfg_put(input bit sel_b, input int chan, input logic [1:0] mode,
                         input int period, input int duty);
    cfg_chan   = chan[1:0];
    cfg_chan_b = chan[2:0];
    cfg_mode   = mode;
    cfg_period = 16'(period);
    cfg_duty   = 4'(duty);
    if (sel_b) begin
      cfg_valid_b = 1'b1;
      chk("cfg_ready_b", int'(cfg_ready_b), 1);
    end else begin
      cfg_valid = 1'b1;
      chk("cfg_ready", int'(cfg_ready), 1);
    end
    @(posedge sys_clk);
    #1;
    cfg_valid   = 1'b0;
    cfg_valid_b = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  // Park on the falling edge of a tick cycle so the accept lands right after it.
  task automatic align_tick();
    while (cyc % 10 != 0) @(negedge sys_clk);
  endtask

  task automatic count_led(input bit sel_b, input int idx, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      cnt += sel_b ? int'(user_led_b[idx]) : int'(user_led[idx]);
    end
  endtask

  initial begin
    int a;
    int cnt;
    int breathe_seq[8];
    breathe_seq = '{0, 1, 2, 3, 2, 1, 0, 1};

    vecs[0] = '{"on_d4",        1, M_ON,      1,   4,  4};
    vecs[1] = '{"on_d15",       1, M_ON,      1,   15, 16};
    vecs[2] = '{"on_d0",        1, M_ON,      1,   0,  0};
    vecs[3] = '{"on_d9",        1, M_ON,      1,   9,  9};
    vecs[4] = '{"on_d1_ch3",    3, M_ON,      5,   1,  1};
    vecs[5] = '{"off_d15",      3, M_OFF,     1,   15, 0};
    vecs[6] = '{"breathe_d0",   3, M_BREATHE, 1,   0,  0};
    vecs[7] = '{"blink_hold_d7",1, M_BLINK,   100, 7,  7};
    vecs[8] = '{"on_d15_ch2",   2, M_ON,      1,   15, 16};

    // reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_user_led", int'(user_led), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 0);
    sys_rst = 1'b0;

    // boot heartbeat and tick cadence
    @(negedge sys_clk);
    chk("boot_user_led", int'(user_led), 1);
    chk("boot_cfg_ready", int'(cfg_ready), 1);
    while (cyc <= 30) begin
      chk("tick_cadence", int'(tick), (cyc % 10 == 0) ? 1 : 0);
      @(negedge sys_clk);
    end

    // steady-level table
    for (int v = 0; v < 9; v++) begin
      cfg_put(1'b0, vecs[v].chan, vecs[v].mode, vecs[v].period, vecs[v].duty);
      @(negedge sys_clk);
      count_led(1'b0, vecs[v].chan, 16, cnt);
      chk(vecs[v].name, cnt, vecs[v].exp_cnt);
    end

    // blink period 3: 30 high, 30 low, first high the cycle after accept
    align_tick();
    cfg_put(1'b0, 2, M_BLINK, 3, 15);
    a = cyc;
    for (int k = 1; k <= 90; k++) begin
      @(negedge sys_clk);
      chk("blink_p3", int'(user_led[2]), (((k - 1) / 30) % 2 == 0) ? 1 : 0);
    end

    // blink period 0 acts as period 1
    align_tick();
    cfg_put(1'b0, 2, M_BLINK, 0, 15);
    for (int k = 1; k <= 40; k++) begin
      @(negedge sys_clk);
      chk("blink_p0", int'(user_led[2]), (((k - 1) / 10) % 2 == 0) ? 1 : 0);
    end

    // collision: rewrite ch2 on the edge where its event would toggle it off
    align_tick();
    cfg_put(1'b0, 2, M_BLINK, 3, 15);
    a = cyc;
    wait_to(a + 29);
    cfg_put(1'b0, 2, M_BLINK, 3, 15);
    count_led(1'b0, 2, 30, cnt);
    chk("collision_high", cnt, 30);
    count_led(1'b0, 2, 30, cnt);
    chk("collision_low", cnt, 0);

    // breathe duty 3, two ticks per step so each level spans a full PWM window
    align_tick();
    cfg_put(1'b0, 3, M_BREATHE, 2, 3);
    a = cyc;
    for (int j = 0; j < 8; j++) begin
      wait_to(a + 20 * j + 1);
      count_led(1'b0, 3, 16, cnt);
      chk("breathe_level", cnt, breathe_seq[j]);
    end

    // out-of-range channel numbers are accepted and dropped
    cfg_put(1'b1, 1, M_ON, 1, 15);
    cfg_put(1'b1, 4, M_ON, 1, 4);
    cfg_put(1'b1, 5, M_ON, 1, 0);
    cfg_put(1'b1, 7, M_OFF, 1, 0);
    @(negedge sys_clk);
    count_led(1'b1, 0, 16, cnt);
    chk("oob_ch0", cnt, 0);
    count_led(1'b1, 1, 16, cnt);
    chk("oob_ch1", cnt, 16);
    count_led(1'b1, 4, 16, cnt);
    chk("oob_ch4", cnt, 4);
    count_led(1'b1, 3, 16, cnt);
    chk("oob_ch3", cnt, 0);

    // heartbeat: off after the 500th tick, back on after the 1000th
    wait_to(5001);
    chk("hb_5001", int'(user_led[0]), 1);
    wait_to(5002);
    chk("hb_5002", int'(user_led[0]), 0);
    wait_to(10001);
    chk("hb_10001", int'(user_led[0]), 0);
    wait_to(10002);
    chk("hb_10002", int'(user_led[0]), 1);

    // asynchronous reset between clock edges
    cfg_put(1'b0, 3, M_BREATHE, 1, 3);
    cfg_put(1'b0, 1, M_ON, 1, 15);
    repeat (25) @(negedge sys_clk);
    chk("pre_rst_ch1", int'(user_led[1]), 1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("async_user_led", int'(user_led), 0);
    chk("async_cfg_ready", int'(cfg_ready), 0);
    chk("async_cfg_ready_b", int'(cfg_ready_b), 0);
    chk("async_tick", int'(tick), 0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge sys_clk);
      chk("post_rst_user_led", int'(user_led), 1);
      chk("post_rst_tick", int'(tick), (k % 10 == 0) ? 1 : 0);
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
